oam_dma_engine: RTL and testbench

//  Sprite-DMA bus master between the CPU core (mem_inputs) and cpu_memory.
//  A CPU write to $4014 triggers it. It stalls the core, then copies 256 bytes

---
 rtl/cpu_defines_pkg.sv | 17 +
 rtl/oam_dma_engine.sv | 91 +++++++++
 tb/tb_oam_dma_engine.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defines_pkg.sv
// Shared CPU-side definitions: sprite DMA state encoding and bus constants.
// Imported by the OAM DMA engine and anything that decodes its state.
package cpu_defines_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } dma_state_t;

   localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;
   localparam logic [15:0] DMA_OAMDATA_ADDR = 16'h2004;
   localparam int          DMA_XFER_LEN     = 256;

endpackage

// File: rtl/oam_dma_engine.sv
// Sprite DMA bus master: copies one page of CPU memory into OAMDATA while
// stalling the core; transparent CPU-to-memory pass-through when idle.
module oam_dma_engine
   import cpu_defines_pkg::*;
#(
   parameter logic [15:0] TRIGGER_ADDR = DMA_TRIGGER_ADDR,
   parameter logic [15:0] OAMDATA_ADDR = DMA_OAMDATA_ADDR,
   parameter int          XFER_LEN     = DMA_XFER_LEN
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clock_en,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_r_en,
   input  logic [7:0]  cpu_w_data,
   input  logic [7:0]  mem_r_data,
   output logic [15:0] mem_addr,
   output logic        mem_r_en,
   output logic [7:0]  mem_w_data,
   output logic        cpu_stall,
   output logic        dma_active
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   dma_state_t state, state_nx;
   logic       parity;
   logic [7:0] page;
   logic [7:0] idx;
   logic       trig;

   assign trig = !cpu_r_en && (cpu_addr == TRIGGER_ADDR);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         parity <= 1'b0;
         page   <= 8'h00;
         idx    <= 8'h00;
      end else if (clock_en) begin
         state  <= state_nx;
         parity <= ~parity;
         if (state == S_IDLE && trig) begin
            page <= cpu_w_data;
            idx  <= 8'h00;
         end else if (state == S_WRITE) begin
            idx <= idx + 8'h01;
         end
      end
   end

   // Reads must land on parity 0, so HALT inserts ALIGN when it lands on parity 0.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (trig) state_nx = S_HALT;
         S_HALT:  state_nx = parity ? S_READ : S_ALIGN;
         S_ALIGN: state_nx = S_READ;
         S_READ:  state_nx = S_WRITE;
         S_WRITE: state_nx = (idx == LAST_IDX) ? S_IDLE : S_READ;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      mem_addr   = cpu_addr;
      mem_r_en   = cpu_r_en;
      mem_w_data = cpu_w_data;
      unique case (state)
         S_IDLE: ;
         S_HALT, S_ALIGN: begin
            mem_addr = 16'h0000;
            mem_r_en = 1'b1;
         end
         S_READ: begin
            mem_addr = {page, idx};
            mem_r_en = 1'b1;
         end
         S_WRITE: begin
            mem_addr   = OAMDATA_ADDR;
            mem_r_en   = 1'b0;
            mem_w_data = mem_r_data;
         end
         default: ;
      endcase
   end

   assign cpu_stall  = (state != S_IDLE);
   assign dma_active = (state != S_IDLE);

endmodule

// File: tb/tb_oam_dma_engine.sv
// Scoreboard bench for the OAM DMA engine: expected OAM bytes are queued at
// trigger time and popped by a monitor on every DMA write to $2004.
module tb_oam_dma_engine;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        clock_en = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic        cpu_r_en = 1'b1;
   logic [7:0]  cpu_w_data = 8'h00;
   logic [7:0]  mem_r_data = 8'h00;
   logic [15:0] mem_addr;
   logic        mem_r_en;
   logic [7:0]  mem_w_data;
   logic        cpu_stall;
   logic        dma_active;

   logic [7:0]  ram [0:65535];
   logic [7:0]  exp_q [$];
   logic [7:0]  mon_exp;
   logic [7:0]  cur_page = 8'h00;
   logic        tb_par;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_wr = 0;
   int          bad_par = 0;

   oam_dma_engine dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .clock_en   (clock_en),
      .cpu_addr   (cpu_addr),
      .cpu_r_en   (cpu_r_en),
      .cpu_w_data (cpu_w_data),
      .mem_r_data (mem_r_data),
      .mem_addr   (mem_addr),
      .mem_r_en   (mem_r_en),
      .mem_w_data (mem_w_data),
      .cpu_stall  (cpu_stall),
      .dma_active (dma_active)
   );

   always #5 clock = ~clock;

   // cpu_memory model: registered read, data valid the cycle after the read
   always @(posedge clock)
      if (clock_en && mem_r_en) mem_r_data <= ram[mem_addr];

   // reference parity: toggles on every enabled edge, cleared by reset
   always @(posedge clock or negedge reset_n)
      if (!reset_n) tb_par <= 1'b0;
      else if (clock_en) tb_par <= ~tb_par;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   // monitor: one pop per enabled DMA write, parity check on page reads
   always @(negedge clock) begin
      if (reset_n && dma_active) begin
         if (clock_en && !mem_r_en && mem_addr == 16'h2004) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               chk("oam_wr_extra", 32'(mem_w_data), 32'hFFFF_FFFF);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("oam_wr", 32'(mem_w_data), 32'(mon_exp));
            end
         end
         if (mem_r_en && mem_addr[15:8] == cur_page && tb_par) bad_par++;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic align(logic want);
      clock_en = 1'b1;
      for (int i = 0; i < 4 && tb_par != want; i++) step();
   endtask

   task automatic push_page(logic [7:0] pg);
      for (int k = 0; k < 256; k++)
         exp_q.push_back(pg == 8'h02 ? (8'(k) ^ 8'h5A) : ~8'(k));
   endtask

   task automatic trigger(logic [7:0] pg);
      cur_page   = pg;
      clock_en   = 1'b1;
      cpu_r_en   = 1'b0;
      cpu_addr   = 16'h4014;
      cpu_w_data = pg;
      #1;
      chk("pass_addr", 32'(mem_addr), 32'h4014);
      chk("pass_wen", 32'(mem_r_en), 0);
      chk("pass_wdata", 32'(mem_w_data), 32'(pg));
      step();
      cpu_r_en = 1'b1;
      cpu_addr = 16'h0300;
   endtask

   task automatic run_xfer(logic [7:0] pg, bit one_in_three, int want_cycles);
      int cnt = 0;
      int it = 0;
      int n0;
      n0 = n_wr;
      bad_par = 0;
      push_page(pg);
      trigger(pg);
      while (cpu_stall && it < 5000) begin
         clock_en = one_in_three ? (it % 3 == 0) : 1'b1;
         if (clock_en) cnt++;
         it++;
         step();
      end
      clock_en = 1'b1;
      chk("stall_timeout", 32'(it < 5000), 1);
      chk("stall_cycles", cnt, want_cycles);
      chk("wr_count", n_wr - n0, 256);
      chk("queue_empty", exp_q.size(), 0);
      chk("read_parity", bad_par, 0);
      chk("idle_after", 32'(dma_active), 0);
   endtask

   initial begin
      int it;
      int n0;
      for (int k = 0; k < 256; k++) begin
         ram[16'h0200 + k] = 8'(k) ^ 8'h5A;
         ram[16'h8000 + k] = ~8'(k);
      end

      // T1: pass-through while held in reset
      for (int i = 0; i < 4; i++) begin
         cpu_addr = 16'($urandom);
         cpu_r_en = 1'($urandom);
         clock_en = 1'($urandom);
         step();
         chk("rst_addr", 32'(mem_addr), 32'(cpu_addr));
         chk("rst_ren", 32'(mem_r_en), 32'(cpu_r_en));
         chk("rst_stall", 32'(cpu_stall), 0);
         chk("rst_active", 32'(dma_active), 0);
      end
      cpu_r_en = 1'b1;
      clock_en = 1'b1;
      reset_n  = 1'b1;
      step();

      // T2: HALT on parity 1 -> 513
      align(1'b0);
      run_xfer(8'h02, 1'b0, 513);

      // T3: HALT on parity 0 -> ALIGN inserted, 514
      align(1'b1);
      run_xfer(8'h02, 1'b0, 514);

      // T4: clock_en 1-in-3
      align(1'b0);
      run_xfer(8'h02, 1'b1, 513);

      // T5: reset at idx $80, then a fresh transfer from PRG $8000
      align(1'b0);
      n0 = n_wr;
      push_page(8'h02);
      trigger(8'h02);
      it = 0;
      while (!(dma_active && mem_r_en && mem_addr == 16'h0280) && it < 2000) begin
         step();
         it++;
      end
      chk("t5_reach", 32'(it < 2000), 1);
      chk("t5_partial", n_wr - n0, 128);
      reset_n = 1'b0;
      #1;
      chk("t5_stall_async", 32'(cpu_stall), 0);
      chk("t5_active_async", 32'(dma_active), 0);
      exp_q.delete();
      step();
      step();
      reset_n = 1'b1;
      step();
      align(1'b0);
      run_xfer(8'h80, 1'b0, 513);

      // T6: read of $4014 and write to $4015 are not triggers
      cpu_r_en = 1'b1;
      cpu_addr = 16'h4014;
      step();
      chk("t6_read", 32'(dma_active), 0);
      cpu_r_en   = 1'b0;
      cpu_addr   = 16'h4015;
      cpu_w_data = 8'h02;
      step();
      chk("t6_write", 32'(dma_active), 0);
      cpu_r_en = 1'b1;
      cpu_addr = 16'h0000;
      repeat (3) step();
      chk("t6_later", 32'(dma_active), 0);
      chk("t6_stall", 32'(cpu_stall), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
